// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops bytes from a synchronous FIFO and sends them as 8N1
// UART frames. Frames follow each other with a two-cycle idle gap, which is
// the time needed to pop the next byte and latch it.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_rd,
  output logic       tx,
  output logic       busy,
  output logic       tx_done,
  output logic [7:0] tx_cnt
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_LATCH = 3'd2;
  localparam logic [2:0] S_START = 3'd3;
  localparam logic [2:0] S_DATA  = 3'd4;
  localparam logic [2:0] S_STOP  = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [7:0]    tx_cnt_q, tx_cnt_d;
  logic          tx_q, tx_d;
  logic          fifo_rd_q, fifo_rd_d;
  // Set by reset; holds off the first IDLE evaluation for one edge so the
  // FIFO sees a quiet cycle after reset release.
  logic          rst_dly_q, rst_dly_d;

  logic baud_end;
  logic start_ok;

  assign baud_end = (baud_q == BAUD_LAST);
  // Only looked at in IDLE and in the last STOP cycle.
  assign start_ok = en && !fifo_empty;

  // Next-state, sequencing counters and shift register.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    tx_cnt_d  = tx_cnt_q;
    rst_dly_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!rst_dly_q && start_ok) state_d = S_FETCH;
      end
      S_FETCH: begin
        state_d = S_LATCH;
      end
      S_LATCH: begin
        // FIFO read data is valid the cycle after the pop.
        shreg_d   = fifo_data;
        baud_d    = '0;
        bit_idx_d = '0;
        state_d   = S_START;
      end
      S_START: begin
        if (baud_end) begin
          baud_d  = '0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      S_DATA: begin
        if (baud_end) begin
          baud_d  = '0;
          shreg_d = {1'b0, shreg_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            bit_idx_d = '0;
            state_d   = S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      S_STOP: begin
        if (baud_end) begin
          baud_d   = '0;
          tx_cnt_d = tx_cnt_q + 8'd1;
          state_d  = start_ok ? S_FETCH : S_IDLE;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Registered outputs are computed from the next state so that they line up
  // with the state they belong to instead of lagging it by one cycle.
  always_comb begin
    tx_d = 1'b1;
    if (state_d == S_START)     tx_d = 1'b0;
    else if (state_d == S_DATA) tx_d = shreg_d[0];
    fifo_rd_d = (state_d == S_FETCH);
  end

  // State and datapath registers; reset aborts any frame in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
      tx_cnt_q  <= '0;
      tx_q      <= 1'b1;
      fifo_rd_q <= 1'b0;
      rst_dly_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
      tx_cnt_q  <= tx_cnt_d;
      tx_q      <= tx_d;
      fifo_rd_q <= fifo_rd_d;
      rst_dly_q <= rst_dly_d;
    end
  end

  assign tx      = tx_q;
  assign fifo_rd = fifo_rd_q;
  assign tx_cnt  = tx_cnt_q;
  assign busy    = (state_q != S_IDLE);
  assign tx_done = (state_q == S_STOP) && baud_end;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx with CLKS_PER_BIT=4 and a small FIFO model.
module tb_fifo_uart_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       fifo_empty;
  logic [7:0] fifo_data = 8'h00;
  logic       fifo_rd, tx, busy, tx_done;
  logic [7:0] tx_cnt;

  int n_cmp = 0;
  int n_mis = 0;

  fifo_uart_tx #(.CLKS_PER_BIT(4)) dut (
    .clk(clk), .rst(rst), .en(en), .fifo_empty(fifo_empty),
    .fifo_data(fifo_data), .fifo_rd(fifo_rd), .tx(tx), .busy(busy),
    .tx_done(tx_done), .tx_cnt(tx_cnt)
  );

  always #5 clk = ~clk;

  // FIFO model: registered read data one cycle after the pop.
  logic [7:0] mem [0:1023];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int uf_cnt = 0;
  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_rd === 1'b1) begin
      if (wr_ptr == rd_ptr) uf_cnt <= uf_cnt + 1;
      else begin
        fifo_data <= mem[rd_ptr];
        rd_ptr    <= rd_ptr + 1;
      end
    end
  end

  // Event counters sampled on the pre-edge values.
  int rd_cnt = 0;
  int done_cnt = 0;
  always @(posedge clk) begin
    if (fifo_rd === 1'b1) rd_cnt <= rd_cnt + 1;
    if (tx_done === 1'b1) done_cnt <= done_cnt + 1;
  end

  task automatic push(input logic [7:0] b);
    mem[wr_ptr] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  // Capture one frame: bits[k] is the line level of bit k (0 = start bit),
  // hold_ok says every bit held steady for 4 cycles, done_pos is the frame
  // cycle of the single tx_done pulse (-1 none, -2 several). Optionally drops
  // en at frame cycle drop_at.
  task automatic capture_frame(input int drop_at, output logic [9:0] bits,
                               output bit hold_ok, output int done_pos,
                               output bit tmo);
    int n;
    n = 0; tmo = 1'b0; hold_ok = 1'b1; done_pos = -1; bits = '0;
    @(negedge clk);
    while (tx !== 1'b0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (tx !== 1'b0) begin
      tmo = 1'b1;
      return;
    end
    for (int c = 0; c < 40; c++) begin
      if (c > 0) @(negedge clk);
      if (c == drop_at) en = 1'b0;
      if (c % 4 == 0) bits[c/4] = tx;
      else if (tx !== bits[c/4]) hold_ok = 1'b0;
      if (tx_done === 1'b1) done_pos = (done_pos == -1) ? c : -2;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; en = 1'b0;
    @(negedge clk); @(negedge clk);
    n_cmp++; if (tx !== 1'b1) begin n_mis++; $display("FAIL reset_tx got=%b want=1", tx); end
    n_cmp++; if (fifo_rd !== 1'b0) begin n_mis++; $display("FAIL reset_fifo_rd got=%b want=0", fifo_rd); end
    n_cmp++; if (busy !== 1'b0) begin n_mis++; $display("FAIL reset_busy got=%b want=0", busy); end
    n_cmp++; if (tx_done !== 1'b0) begin n_mis++; $display("FAIL reset_tx_done got=%b want=0", tx_done); end
    n_cmp++; if (tx_cnt !== 8'd0) begin n_mis++; $display("FAIL reset_tx_cnt got=%0d want=0", tx_cnt); end
  endtask

  // Single 0xA5 frame; also covers the quiet first edge after reset release.
  task automatic test_single;
    logic [9:0] bits; bit hold_ok, tmo; int done_pos, rd0, d0;
    push(8'hA5); en = 1'b1;
    @(negedge clk);
    rd0 = rd_cnt; d0 = done_cnt;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (fifo_rd !== 1'b0 || busy !== 1'b0) begin n_mis++; $display("FAIL release_hold fifo_rd=%b busy=%b want 0/0", fifo_rd, busy); end
    @(negedge clk);
    n_cmp++; if (fifo_rd !== 1'b1) begin n_mis++; $display("FAIL release_fetch fifo_rd=%b want=1", fifo_rd); end
    capture_frame(-1, bits, hold_ok, done_pos, tmo);
    n_cmp++; if (tmo || !hold_ok || bits !== 10'b1_1010_0101_0) begin n_mis++; $display("FAIL single_frame got=%b hold=%0d tmo=%0d want=%b", bits, hold_ok, tmo, 10'b1_1010_0101_0); end
    n_cmp++; if (done_pos !== 39) begin n_mis++; $display("FAIL single_done_pos got=%0d want=39", done_pos); end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0 || tx !== 1'b1 || fifo_rd !== 1'b0) begin n_mis++; $display("FAIL single_idle busy=%b tx=%b rd=%b want 0/1/0", busy, tx, fifo_rd); end
    repeat (3) @(negedge clk);
    n_cmp++; if (rd_cnt - rd0 !== 1) begin n_mis++; $display("FAIL single_rd_pulses got=%0d want=1", rd_cnt - rd0); end
    n_cmp++; if (done_cnt - d0 !== 1) begin n_mis++; $display("FAIL single_done_pulses got=%0d want=1", done_cnt - d0); end
    n_cmp++; if (tx_cnt !== 8'd1) begin n_mis++; $display("FAIL single_tx_cnt got=%0d want=1", tx_cnt); end
  endtask

  task automatic test_no_data;
    bit bad; int rd0;
    en = 1'b1; bad = 1'b0; rd0 = rd_cnt;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (fifo_rd !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) bad = 1'b1;
    end
    n_cmp++; if (bad) begin n_mis++; $display("FAIL empty_idle saw activity while FIFO empty (want rd=0 tx=1 busy=0)"); end
    n_cmp++; if (rd_cnt - rd0 !== 0) begin n_mis++; $display("FAIL empty_rd_pulses got=%0d want=0", rd_cnt - rd0); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] bytes [3];
    logic [9:0] bits, want; bit hold_ok, tmo; int done_pos, rd0;
    logic [7:0] cnt_want;
    bytes[0] = 8'h00; bytes[1] = 8'hFF; bytes[2] = 8'h55;
    rd0 = rd_cnt; cnt_want = tx_cnt + 8'd3;
    for (int i = 0; i < 3; i++) push(bytes[i]);
    for (int i = 0; i < 3; i++) begin
      want = {1'b1, bytes[i], 1'b0};
      capture_frame(-1, bits, hold_ok, done_pos, tmo);
      n_cmp++; if (tmo || !hold_ok || bits !== want) begin n_mis++; $display("FAIL b2b_frame%0d got=%b hold=%0d tmo=%0d want=%b", i, bits, hold_ok, tmo, want); end
      n_cmp++; if (done_pos !== 39) begin n_mis++; $display("FAIL b2b_done_pos%0d got=%0d want=39", i, done_pos); end
      @(negedge clk);
      n_cmp++; if (tx !== 1'b1 || fifo_rd !== (i < 2)) begin n_mis++; $display("FAIL b2b_gap0_%0d tx=%b rd=%b want tx=1 rd=%0d", i, tx, fifo_rd, i < 2); end
      @(negedge clk);
      n_cmp++; if (tx !== 1'b1 || fifo_rd !== 1'b0) begin n_mis++; $display("FAIL b2b_gap1_%0d tx=%b rd=%b want 1/0", i, tx, fifo_rd); end
    end
    repeat (2) @(negedge clk);
    n_cmp++; if (rd_cnt - rd0 !== 3) begin n_mis++; $display("FAIL b2b_rd_pulses got=%0d want=3", rd_cnt - rd0); end
    n_cmp++; if (tx_cnt !== cnt_want) begin n_mis++; $display("FAIL b2b_tx_cnt got=%0d want=%0d", tx_cnt, cnt_want); end
  endtask

  // en drops during data bit 2; the frame finishes and nothing else is fetched.
  task automatic test_en_drop;
    logic [9:0] bits; bit hold_ok, tmo; int done_pos, rd0, d0;
    logic [7:0] cnt_want;
    rd0 = rd_cnt; d0 = done_cnt; cnt_want = tx_cnt + 8'd1;
    en = 1'b1;
    push(8'h3C); push(8'h81);
    capture_frame(13, bits, hold_ok, done_pos, tmo);
    n_cmp++; if (tmo || !hold_ok || bits !== 10'b1_0011_1100_0) begin n_mis++; $display("FAIL endrop_frame got=%b hold=%0d tmo=%0d want=%b", bits, hold_ok, tmo, 10'b1_0011_1100_0); end
    n_cmp++; if (done_pos !== 39) begin n_mis++; $display("FAIL endrop_done_pos got=%0d want=39", done_pos); end
    repeat (20) @(negedge clk);
    n_cmp++; if (busy !== 1'b0 || tx !== 1'b1) begin n_mis++; $display("FAIL endrop_idle busy=%b tx=%b want 0/1", busy, tx); end
    n_cmp++; if (rd_cnt - rd0 !== 1) begin n_mis++; $display("FAIL endrop_rd_pulses got=%0d want=1", rd_cnt - rd0); end
    n_cmp++; if (done_cnt - d0 !== 1) begin n_mis++; $display("FAIL endrop_done_pulses got=%0d want=1", done_cnt - d0); end
    n_cmp++; if (tx_cnt !== cnt_want) begin n_mis++; $display("FAIL endrop_tx_cnt got=%0d want=%0d", tx_cnt, cnt_want); end
  endtask

  // Reset during data bit 3 of the pending 0x81 frame, then send 0x5A.
  task automatic test_reset_mid;
    logic [9:0] bits; bit hold_ok, tmo; int done_pos, n;
    en = 1'b1; n = 0;
    @(negedge clk);
    while (tx !== 1'b0 && n < 50) begin @(negedge clk); n++; end
    n_cmp++; if (tx !== 1'b0) begin n_mis++; $display("FAIL rstmid_start timeout tx=%b want=0", tx); end
    repeat (17) @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++; if (tx !== 1'b1 || busy !== 1'b0 || fifo_rd !== 1'b0) begin n_mis++; $display("FAIL rstmid_abort tx=%b busy=%b rd=%b want 1/0/0", tx, busy, fifo_rd); end
    n_cmp++; if (tx_cnt !== 8'd0) begin n_mis++; $display("FAIL rstmid_tx_cnt got=%0d want=0", tx_cnt); end
    @(negedge clk);
    push(8'h5A);
    rst = 1'b0;
    capture_frame(-1, bits, hold_ok, done_pos, tmo);
    n_cmp++; if (tmo || !hold_ok || bits !== 10'b1_0101_1010_0) begin n_mis++; $display("FAIL rstmid_frame got=%b hold=%0d tmo=%0d want=%b", bits, hold_ok, tmo, 10'b1_0101_1010_0); end
    repeat (2) @(negedge clk);
    n_cmp++; if (tx_cnt !== 8'd1) begin n_mis++; $display("FAIL rstmid_tx_cnt_after got=%0d want=1", tx_cnt); end
  endtask

  // 256 frames from a cleared counter: wrap to 0 exactly at the 256th pulse.
  task automatic test_wrap;
    bit bad, tmo; int n; logic [7:0] pre255, post255, pre256, post256;
    bad = 1'b0; tmo = 1'b0;
    pre255 = 8'hxx; post255 = 8'hxx; pre256 = 8'hxx; post256 = 8'hxx;
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 256; i++) push(8'(i));
    en = 1'b1; rst = 1'b0;
    for (int k = 1; k <= 256; k++) begin
      n = 0;
      while (tx_done !== 1'b1 && n < 100) begin @(negedge clk); n++; end
      if (tx_done !== 1'b1) begin tmo = 1'b1; break; end
      if (tx_cnt !== 8'(k - 1)) bad = 1'b1;
      if (k == 255) pre255 = tx_cnt;
      if (k == 256) pre256 = tx_cnt;
      @(negedge clk);
      if (tx_cnt !== 8'(k)) bad = 1'b1;
      if (k == 255) post255 = tx_cnt;
      if (k == 256) post256 = tx_cnt;
    end
    n_cmp++; if (tmo) begin n_mis++; $display("FAIL wrap_timeout tx_done pulse missing, want 256 pulses"); end
    n_cmp++; if (bad) begin n_mis++; $display("FAIL wrap_sequence tx_cnt did not follow pulse count"); end
    n_cmp++; if (pre255 !== 8'd254 || post255 !== 8'd255) begin n_mis++; $display("FAIL wrap_255 got=%0d->%0d want=254->255", pre255, post255); end
    n_cmp++; if (pre256 !== 8'd255 || post256 !== 8'd0) begin n_mis++; $display("FAIL wrap_256 got=%0d->%0d want=255->0", pre256, post256); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_no_data();
    test_back_to_back();
    test_en_drop();
    test_reset_mid();
    test_wrap();
    n_cmp++; if (uf_cnt !== 0) begin n_mis++; $display("FAIL underflow got=%0d want=0", uf_cnt); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 16, meaning clock cycles per serial bit (legal range >= 2).
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port en, input, 1 bit: enables fetching of new bytes from the FIFO.
REQ-005 The block SHALL have port fifo_empty, input, 1 bit: empty flag of the upstream synchronous FIFO.
REQ-006 The block SHALL have port fifo_data, input, 8 bits: FIFO read data, registered one cycle after fifo_rd.
REQ-007 The block SHALL have port fifo_rd, output, 1 bit: FIFO pop strobe, registered.
REQ-008 The block SHALL have port tx, output, 1 bit: serial line, idle high, registered.
REQ-009 The block SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.
REQ-010 The block SHALL have port tx_done, output, 1 bit: one-cycle pulse at the end of each stop bit.
REQ-011 The block SHALL have port tx_cnt, output, 8 bits: count of completed frames, wrapping 255 -> 0.

Function
REQ-012 The FSM SHALL have exactly these states: IDLE, FETCH, LATCH, START, DATA, STOP.
REQ-013 In IDLE, if en=1 and fifo_empty=0, the FSM SHALL go to FETCH on the next edge; otherwise it SHALL stay in IDLE.
REQ-014 fifo_rd SHALL be high for exactly the one cycle spent in FETCH and low in every other state; FETCH SHALL always go to LATCH.
REQ-015 In LATCH, the shift register SHALL capture fifo_data at the end of the cycle, and the FSM SHALL go to START.
REQ-016 In START, tx SHALL be 0 for CLKS_PER_BIT cycles.
REQ-017 In DATA, 8 bits SHALL be sent LSB first, each held for CLKS_PER_BIT cycles; a 3-bit bit index and a baud counter of width clog2(CLKS_PER_BIT) SHALL sequence the bits.
REQ-018 In STOP, tx SHALL be 1 for CLKS_PER_BIT cycles.
REQ-019 A frame SHALL last exactly 10*CLKS_PER_BIT cycles, from START entry to STOP exit.
REQ-020 In the last STOP cycle, tx_done SHALL pulse for 1 cycle and tx_cnt SHALL increment modulo 256.
REQ-021 On STOP exit, if en=1 and fifo_empty=0, the FSM SHALL go directly to FETCH; otherwise it SHALL go to IDLE.
REQ-022 With back-to-back frames, the inter-frame idle (tx=1) gap SHALL be exactly 2 cycles (FETCH and LATCH).
REQ-023 fifo_empty and en SHALL be sampled only in IDLE and in the last STOP cycle; en falling mid-frame SHALL NOT abort the frame.
REQ-024 The block SHALL never assert fifo_rd while fifo_empty=1 (no underflow).
REQ-025 tx SHALL be 1 in IDLE, FETCH and LATCH, and SHALL be glitch-free (driven from a flop).

Reset
REQ-026 While rst=1, asynchronously: state SHALL be IDLE, tx SHALL be 1, and fifo_rd, busy, tx_done, tx_cnt, the shift register, the bit index and the baud counter SHALL be 0.
REQ-027 Reset asserted mid-frame SHALL abort the frame immediately; the partial byte is lost and is not counted.
REQ-028 On the first edge after rst deasserts, fifo_rd SHALL remain 0; normal IDLE evaluation SHALL resume from the following cycle.

Verification (CLKS_PER_BIT=4)
REQ-029 Single byte 0xA5, en=1 -> one fifo_rd pulse; tx = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; one tx_done pulse; tx_cnt=1.
REQ-030 Bytes 0x00, 0xFF, 0x55 queued -> three fifo_rd pulses; 2-cycle tx=1 gaps between frames; correct bit patterns; tx_cnt=3.
REQ-031 fifo_empty=1 with en=1 for 100 cycles -> fifo_rd never asserts, tx=1, busy=0.
REQ-032 en dropped during DATA bit 2 with FIFO non-empty -> the current frame completes with tx_done; no further fifo_rd; FSM returns to IDLE.
REQ-033 rst pulsed during DATA bit 3 -> tx=1, busy=0 and tx_cnt=0 immediately; after release, the next byte is fetched and sent as a complete frame.
REQ-034 256 consecutive frames -> tx_cnt wraps to 0 exactly at the 256th tx_done pulse.
